// File: rtl/piso_shift.sv
// Parallel-in/serial-out shift stage fed by a registered word. Valid/ready on the
// load side and on the serial side; a word can load on the last beat of the previous one.

module piso_shift_checker #(
    parameter int CW = 4
) (
    input logic          clk,
    input logic          rst_n,
    input logic          load_ready,
    input logic          ser,
    input logic          ser_valid,
    input logic          ser_ready,
    input logic          busy,
    input logic [CW-1:0] cnt,
    input logic          done
);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    a_busy_is_valid: assert property (@(posedge clk) disable iff (!rst_n)
        busy == ser_valid);

    a_idle_outputs: assert property (@(posedge clk) disable iff (!rst_n)
        !ser_valid |-> (load_ready && !ser && (cnt == CNT_ZERO)));

    a_shift_has_bits: assert property (@(posedge clk) disable iff (!rst_n)
        ser_valid |-> (cnt != CNT_ZERO));

    a_stall_holds: assert property (@(posedge clk) disable iff (!rst_n)
        (ser_valid && !ser_ready) |=> (ser_valid && $stable(ser) && $stable(cnt)));

    a_done_after_last: assert property (@(posedge clk) disable iff (!rst_n)
        (ser_valid && ser_ready && (cnt == CNT_LAST)) |=> done);

    a_done_only_after_last: assert property (@(posedge clk) disable iff (!rst_n)
        !(ser_valid && ser_ready && (cnt == CNT_LAST)) |=> !done);
endmodule

module piso_shift #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       load_valid_i,
    output logic                       load_ready_o,
    input  logic [WIDTH-1:0]           d_i,
    output logic                       ser_o,
    output logic                       ser_valid_o,
    input  logic                       ser_ready_i,
    output logic                       busy_o,
    output logic [$clog2(WIDTH+1)-1:0] cnt_o,
    output logic                       done_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Moves the word one place toward the output end, zero-filling behind it.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = w << 1'b1;
        end else begin
            r = w >> 1'b1;
        end
        return r;
    endfunction

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        logic b;
        if (MSB_FIRST) begin
            b = w[WIDTH-1];
        end else begin
            b = w[0];
        end
        return b;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] sreg_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             valid_r;
    logic             busy_r;
    logic             last_s;
    logic             beat_s;
    logic             load_ready_s;
    logic             load_s;

    // Handshake decode; load_ready passes ser_ready straight through on the last bit
    always_comb begin
        last_s       = (cnt_r == CNT_LAST);
        beat_s       = (state_r == ST_SHIFT) && ser_ready_i;
        load_ready_s = (state_r == ST_IDLE) ||
                       ((state_r == ST_SHIFT) && last_s && ser_ready_i);
        load_s       = load_valid_i && load_ready_s;
    end

    // Next state, next shift-register contents and completion pulse
    always_comb begin
        state_nxt_s = state_r;
        sreg_nxt_s  = sreg_r;
        cnt_nxt_s   = cnt_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_nxt_s = ST_SHIFT;
                    sreg_nxt_s  = d_i;
                    cnt_nxt_s   = CNT_FULL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (beat_s && last_s) begin
                    done_nxt_s = 1'b1;
                    if (load_s) begin
                        state_nxt_s = ST_SHIFT;
                        sreg_nxt_s  = d_i;
                        cnt_nxt_s   = CNT_FULL;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        sreg_nxt_s  = WORD_ZERO;
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end else if (beat_s) begin
                    sreg_nxt_s = shift_word(sreg_r);
                    cnt_nxt_s  = cnt_r - CNT_LAST;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                sreg_nxt_s  = WORD_ZERO;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, data and registered status outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
            sreg_r  <= WORD_ZERO;
            cnt_r   <= CNT_ZERO;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            sreg_r  <= sreg_nxt_s;
            cnt_r   <= cnt_nxt_s;
            done_r  <= done_nxt_s;
            valid_r <= (state_nxt_s == ST_SHIFT);
            busy_r  <= (state_nxt_s == ST_SHIFT);
        end
    end

    assign load_ready_o = load_ready_s;
    assign ser_o        = out_bit(sreg_r);
    assign ser_valid_o  = valid_r;
    assign busy_o       = busy_r;
    assign cnt_o        = cnt_r;
    assign done_o       = done_r;

    piso_shift_checker #(
        .CW(CW)
    ) u_checker (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .load_ready (load_ready_o),
        .ser        (ser_o),
        .ser_valid  (ser_valid_o),
        .ser_ready  (ser_ready_i),
        .busy       (busy_o),
        .cnt        (cnt_o),
        .done       (done_o)
    );
endmodule

// File: tb/tb_piso_shift.sv
// Scoreboard bench for piso_shift: MSB-first and LSB-first 8-bit instances plus a 1-bit instance.

module tb_piso_shift;
    typedef struct packed {
        logic       b;
        logic [3:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic       a_lv, a_lr, a_ser, a_sv, a_sr, a_busy, a_done;
    logic [7:0] a_d;
    logic [3:0] a_cnt;
    logic       b_lv, b_lr, b_ser, b_sv, b_sr, b_busy, b_done;
    logic [7:0] b_d;
    logic [3:0] b_cnt;
    logic       c_lv, c_lr, c_ser, c_sv, c_sr, c_busy, c_done;
    logic [0:0] c_d;
    logic [0:0] c_cnt;

    exp_t a_q[$];
    exp_t b_q[$];
    exp_t c_q[$];

    piso_shift #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .load_valid_i(a_lv), .load_ready_o(a_lr),
        .d_i(a_d), .ser_o(a_ser), .ser_valid_o(a_sv), .ser_ready_i(a_sr),
        .busy_o(a_busy), .cnt_o(a_cnt), .done_o(a_done));

    piso_shift #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .load_valid_i(b_lv), .load_ready_o(b_lr),
        .d_i(b_d), .ser_o(b_ser), .ser_valid_o(b_sv), .ser_ready_i(b_sr),
        .busy_o(b_busy), .cnt_o(b_cnt), .done_o(b_done));

    piso_shift #(.WIDTH(1), .MSB_FIRST(1'b1)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .load_valid_i(c_lv), .load_ready_o(c_lr),
        .d_i(c_d), .ser_o(c_ser), .ser_valid_o(c_sv), .ser_ready_i(c_sr),
        .busy_o(c_busy), .cnt_o(c_cnt), .done_o(c_done));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int s);
        int n;
        case (s)
            0:       n = a_q.size();
            1:       n = b_q.size();
            default: n = c_q.size();
        endcase
        return n;
    endfunction

    // Monitor for the MSB-first instance: pops one expectation per accepted beat
    logic       a_pend = 1'b0, a_stall = 1'b0, a_pser = 1'b0;
    logic [3:0] a_pcnt = 4'd0;
    exp_t       a_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_pend = 1'b0; a_stall = 1'b0;
        end else begin
            check("a_done", 32'(a_done), 32'(a_pend));
            if (a_stall) begin
                check("a_stall_valid", 32'(a_sv), 32'(1'b1));
                check("a_stall_ser", 32'(a_ser), 32'(a_pser));
                check("a_stall_cnt", 32'(a_cnt), 32'(a_pcnt));
            end
            a_pend = 1'b0;
            a_stall = a_sv && !a_sr; a_pser = a_ser; a_pcnt = a_cnt;
            if (a_sv && a_sr) begin
                if (a_q.size() == 0) begin
                    check("a_unexpected_beat", 32'(a_sv), 32'(1'b0));
                end else begin
                    a_e = a_q.pop_front();
                    check("a_ser", 32'(a_ser), 32'(a_e.b));
                    check("a_cnt", 32'(a_cnt), 32'(a_e.c));
                    a_pend = (a_e.c == 4'd1);
                end
            end
        end
    end

    // Monitor for the LSB-first instance
    logic b_pend = 1'b0;
    exp_t b_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            b_pend = 1'b0;
        end else begin
            check("b_done", 32'(b_done), 32'(b_pend));
            b_pend = 1'b0;
            if (b_sv && b_sr) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected_beat", 32'(b_sv), 32'(1'b0));
                end else begin
                    b_e = b_q.pop_front();
                    check("b_ser", 32'(b_ser), 32'(b_e.b));
                    check("b_cnt", 32'(b_cnt), 32'(b_e.c));
                    b_pend = (b_e.c == 4'd1);
                end
            end
        end
    end

    // Monitor for the 1-bit instance
    logic c_pend = 1'b0;
    exp_t c_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            c_pend = 1'b0;
        end else begin
            check("c_done", 32'(c_done), 32'(c_pend));
            c_pend = 1'b0;
            if (c_sv && c_sr) begin
                if (c_q.size() == 0) begin
                    check("c_unexpected_beat", 32'(c_sv), 32'(1'b0));
                end else begin
                    c_e = c_q.pop_front();
                    check("c_ser", 32'(c_ser), 32'(c_e.b));
                    check("c_cnt", 32'(c_cnt), 32'(c_e.c));
                    c_pend = (c_e.c == 4'd1);
                end
            end
        end
    end

    // seq lists the serial bits in output order, leftmost first
    task automatic push8(input int s, input logic [7:0] seq);
        for (int i = 0; i < 8; i++) begin
            if (s == 0) a_q.push_back(exp_t'{seq[7-i], 4'(8 - i)});
            else        b_q.push_back(exp_t'{seq[7-i], 4'(8 - i)});
        end
    endtask

    task automatic load_a(input logic [7:0] v);
        int n = 0;
        a_lv = 1'b1; a_d = v;
        @(negedge clk);
        while (a_lr !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (a_lr !== 1'b1) check("a_load_timeout", 32'(a_lr), 32'(1'b1));
        @(posedge clk); #1;
        a_lv = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] v);
        int n = 0;
        b_lv = 1'b1; b_d = v;
        @(negedge clk);
        while (b_lr !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (b_lr !== 1'b1) check("b_load_timeout", 32'(b_lr), 32'(1'b1));
        @(posedge clk); #1;
        b_lv = 1'b0;
    endtask

    task automatic drain(input int s);
        int n = 0;
        while (qsize(s) != 0 && n < 300) begin @(posedge clk); n++; end
        if (qsize(s) != 0) check("drain_timeout", 32'(qsize(s)), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int s);
        case (s)
            0: begin
                check("a_idle_busy", 32'(a_busy), 32'd0); check("a_idle_cnt", 32'(a_cnt), 32'd0);
                check("a_idle_valid", 32'(a_sv), 32'd0);  check("a_idle_ready", 32'(a_lr), 32'd1);
            end
            1: begin
                check("b_idle_busy", 32'(b_busy), 32'd0); check("b_idle_cnt", 32'(b_cnt), 32'd0);
                check("b_idle_valid", 32'(b_sv), 32'd0);  check("b_idle_ready", 32'(b_lr), 32'd1);
            end
            default: begin
                check("c_idle_busy", 32'(c_busy), 32'd0); check("c_idle_cnt", 32'(c_cnt), 32'd0);
                check("c_idle_valid", 32'(c_sv), 32'd0);  check("c_idle_ready", 32'(c_lr), 32'd1);
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running, expected to have finished");
        $fatal(1);
    end

    logic [3:0] c_seq;

    initial begin
        rst_n = 1'b0;
        a_lv = 1'b0; a_d = 8'h00; a_sr = 1'b0;
        b_lv = 1'b0; b_d = 8'h00; b_sr = 1'b0;
        c_lv = 1'b0; c_d = 1'b0;  c_sr = 1'b0;
        #2;
        check("rst_ser", 32'(a_ser), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check_idle(0); check_idle(1); check_idle(2);
        #20;
        rst_n = 1'b1;
        #1;
        check("rel_ready_a", 32'(a_lr), 32'd1);
        @(posedge clk); #1;

        // MSB-first 8'haa
        a_sr = 1'b1;
        push8(0, 8'b10101010);
        load_a(8'haa);
        drain(0);
        check_idle(0);

        // LSB-first 8'h55 and 8'h0f
        b_sr = 1'b1;
        push8(1, 8'b10101010);
        load_b(8'h55);
        drain(1);
        push8(1, 8'b11110000);
        load_b(8'h0f);
        drain(1);
        check_idle(1);

        // Backpressure with a non-accepted load attempt of 8'hff mid-word
        a_sr = 1'b0;
        push8(0, 8'b11000011);
        load_a(8'hc3);
        a_lv = 1'b1; a_d = 8'hff;
        for (int i = 0; i < 4; i++) begin
            a_sr = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            check("a_shift_no_load", 32'(a_lr), 32'd0);
            @(posedge clk); #1;
        end
        a_lv = 1'b0;
        for (int i = 0; i < 200 && a_q.size() != 0; i++) begin
            a_sr = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        a_sr = 1'b1;
        drain(0);
        check_idle(0);

        // Back-to-back words without a bubble
        push8(0, 8'b10101010);
        push8(0, 8'b01010101);
        load_a(8'haa);
        fork
            load_a(8'h55);
            repeat (16) begin
                @(negedge clk);
                check("a_b2b_gap", 32'(a_sv), 32'd1);
            end
        join
        drain(0);
        check_idle(0);

        // 1-bit instance: one word per cycle
        c_sr = 1'b1;
        c_seq = 4'b1011;
        for (int i = 0; i < 4; i++) c_q.push_back(exp_t'{c_seq[3-i], 4'd1});
        c_lv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_d = c_seq[3-i];
            @(negedge clk);
            check("c_ready", 32'(c_lr), 32'd1);
            @(posedge clk); #1;
        end
        c_lv = 1'b0;
        drain(2);
        check_idle(2);

        // Asynchronous reset after three beats of 8'haa
        a_sr = 1'b1;
        push8(0, 8'b10101010);
        load_a(8'haa);
        repeat (3) @(posedge clk);
        #1;
        check("a_mid_cnt", 32'(a_cnt), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        check("a_rst_valid", 32'(a_sv), 32'd0);
        check("a_rst_cnt", 32'(a_cnt), 32'd0);
        check("a_rst_busy", 32'(a_busy), 32'd0);
        check("a_rst_ser", 32'(a_ser), 32'd0);
        check("a_rst_done", 32'(a_done), 32'd0);
        a_q.delete();
        rst_n = 1'b1;
        #1;
        check("a_rst_ready", 32'(a_lr), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check_idle(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
